// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants, reused by the write-register mux and forwarding logic.
package mips_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with hazard detection and the issue stall.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] rt_addr,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic                 issue_valid,
    input  logic                 issue_mark,
    input  logic [REG_IDX_W-1:0] issue_dst,
    output logic                 stall,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rs_hz;
    logic             rt_hz;
    logic             waw_hz;
    logic             do_set;

    // A writeback landing this cycle resolves the hazard on its register immediately.
    function automatic logic hazard(input logic [NREGS-1:0] busy,
                                    input reg_idx_t idx,
                                    input logic we,
                                    input reg_idx_t wa);
        return (idx != REG_ZERO) && busy[idx] && !(we && (wa == idx));
    endfunction

    always_comb begin
        rs_hz  = hazard(busy_q, rs_addr, wr_en, wr_addr);
        rt_hz  = hazard(busy_q, rt_addr, wr_en, wr_addr);
        waw_hz = issue_mark && hazard(busy_q, issue_dst, wr_en, wr_addr);
        stall  = issue_valid && (rs_hz || rt_hz || waw_hz);
        do_set = issue_valid && issue_mark && !stall && (issue_dst != REG_ZERO);
    end

    // Set is applied after clear so it wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (do_set) begin
            busy_d[issue_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/mips_regfile.sv
// MIPS GPR file: two combinational read ports with writeback bypass, one write port, scoreboard.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 issue_valid,
    input  logic                 issue_mark,
    input  logic [REG_IDX_W-1:0] issue_dst,
    output logic                 stall,
    output logic [NREGS-1:0]     busy_vec
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end else begin
            rs_data = regs_q[rs_addr];
        end

        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

    reg_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_valid(issue_valid),
        .issue_mark (issue_mark),
        .issue_dst  (issue_dst),
        .stall      (stall),
        .busy_vec   (busy_vec)
    );

endmodule
